mux_scan_nto1: RTL

//  Parametrised, registered N:1 multiplexer; successor to the fixed 16:1 combinational mux.
//  Two modes:
//   - manual: select driven by sel.
//   - scan: internal sequencer steps through every channel, holding each for DWELL cycles.

---
 rtl/mux_scan_pkg.sv | 17 +
 rtl/mux_scan_seq.sv | 97 +++++++++
 rtl/mux_scan_nto1.sv | 113 +++++++++++
 3 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the registered N:1 scan multiplexer.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_e;

    // $clog2 clamped to at least 1 so derived vector widths are never zero.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = $clog2(n);
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/mux_scan_seq.sv
// Mode FSM plus channel-index and dwell counters for the scan multiplexer.
module mux_scan_seq
    import mux_scan_pkg::*;
#(
    parameter int unsigned CHANNELS = 16,
    parameter int unsigned SEL_W    = clog2_min1(CHANNELS),
    parameter int unsigned DWELL    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic             mode_i,
    input  logic             start_i,
    output logic [SEL_W-1:0] idx_o,
    output logic             manual_c_o,
    output logic             scan_c_o,
    output logic             done_pre_c_o
);

    localparam int unsigned DW_W = clog2_min1(DWELL + 1);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CHANNELS - 1);
    localparam logic [DW_W-1:0]  LAST_DW  = DW_W'(DWELL - 1);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  idx_q, idx_d;
    logic [DW_W-1:0]   dwell_q, dwell_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        dwell_d      = dwell_q;
        manual_c_o   = 1'b0;
        scan_c_o     = 1'b0;
        done_pre_c_o = 1'b0;

        if (!enable_i) begin
            // Disable aborts everything, including a scan in flight.
            state_d = IDLE;
            idx_d   = '0;
            dwell_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    idx_d   = '0;
                    dwell_d = '0;
                    if (!mode_i) begin
                        state_d = MANUAL;
                    end else if (start_i) begin
                        state_d = SCAN;
                    end
                end
                MANUAL: begin
                    if (mode_i) begin
                        state_d = IDLE;
                    end else begin
                        manual_c_o = 1'b1;
                    end
                end
                SCAN: begin
                    scan_c_o = 1'b1;
                    if (dwell_q == LAST_DW) begin
                        dwell_d = '0;
                        if (idx_q == LAST_IDX) begin
                            done_pre_c_o = 1'b1;
                            state_d      = IDLE;
                            idx_d        = '0;
                        end else begin
                            idx_d = idx_q + SEL_W'(1);
                        end
                    end else begin
                        dwell_d = dwell_q + DW_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                    dwell_d = '0;
                end
            endcase
        end
    end

    assign idx_o = idx_q;

endmodule

// File: rtl/mux_scan_nto1.sv
// Registered N:1 multiplexer with manual select and an automatic single-pass scan mode.
module mux_scan_nto1
    import mux_scan_pkg::*;
#(
    parameter int unsigned CHANNELS = 16,
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned SEL_W    = clog2_min1(CHANNELS),
    parameter int unsigned DWELL    = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] A,
    input  logic                      enable,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      start,
    output logic [WIDTH-1:0]          Y,
    output logic                      valid,
    output logic [SEL_W-1:0]          cur_sel,
    output logic                      busy,
    output logic                      done
);

    localparam logic [SEL_W:0] CH_CNT = (SEL_W + 1)'(CHANNELS);

    logic [SEL_W-1:0] idx;
    logic             manual_c;
    logic             scan_c;
    logic             done_pre_c;

    mux_scan_seq #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W),
        .DWELL    (DWELL)
    ) u_seq (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable),
        .mode_i       (mode),
        .start_i      (start),
        .idx_o        (idx),
        .manual_c_o   (manual_c),
        .scan_c_o     (scan_c),
        .done_pre_c_o (done_pre_c)
    );

    logic [SEL_W-1:0] pick_c;
    logic [WIDTH-1:0] pick_data_c;
    logic             sel_ok_c;

    assign pick_c   = scan_c ? idx : sel;
    assign sel_ok_c = ({1'b0, sel} < CH_CNT);

    // Decoded slice select; an index beyond the last channel yields zero.
    always_comb begin
        pick_data_c = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (pick_c == SEL_W'(k)) begin
                pick_data_c = A[k*WIDTH +: WIDTH];
            end
        end
    end

    logic [WIDTH-1:0] y_q, y_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        y_d       = '0;
        valid_d   = 1'b0;
        cur_sel_d = '0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        if (scan_c) begin
            y_d       = pick_data_c;
            valid_d   = 1'b1;
            cur_sel_d = idx;
            busy_d    = 1'b1;
            done_d    = done_pre_c;
        end else if (manual_c) begin
            cur_sel_d = sel;
            if (sel_ok_c) begin
                y_d     = pick_data_c;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q       <= '0;
            valid_q   <= 1'b0;
            cur_sel_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            y_q       <= y_d;
            valid_q   <= valid_d;
            cur_sel_q <= cur_sel_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign Y       = y_q;
    assign valid   = valid_q;
    assign cur_sel = cur_sel_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
